// File: rtl/tick_sprite_mover.sv
// tick_sprite_mover
//   Steps a single-pixel sprite one position per 4 Hz tick in the direction
//   held on the keys. Each move first erases the old pixel, then draws the
//   new one, through a req/ack handshake to the VGA plot stage.
//
// Build option:
//   TICK_SPRITE_MOVER_WRAP_EN  defined   -> moves off an edge wrap around
//                              undefined -> moves off an edge are dropped
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-low
//   tick         one-cycle step pulse
//   dir          {up,down,left,right} key levels, priority up>down>left>right
//   plot_ack     plotter accepted the current pixel
//   plot_req     pixel request to the plotter
//   plot_x/y     pixel coordinate (stable while plot_req is high)
//   plot_colour  pixel colour
//   pos_x/y      current sprite position
//   busy         high whenever not idle
//   tick_missed  saturating count of ticks dropped while busy
module tick_sprite_mover #(
  parameter logic [7:0] X_MAX     = 8'd159,
  parameter logic [6:0] Y_MAX     = 7'd119,
  parameter logic [7:0] X_INIT    = 8'd80,
  parameter logic [6:0] Y_INIT    = 7'd60,
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] dir,
  input  logic       plot_ack,
  output logic       plot_req,
  output logic [7:0] plot_x,
  output logic [6:0] plot_y,
  output logic [2:0] plot_colour,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic       busy,
  output logic [7:0] tick_missed
);

`ifdef TICK_SPRITE_MOVER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  pos_x_q, pos_x_d;
  logic [6:0]  pos_y_q, pos_y_d;
  logic [7:0]  nxt_x_q, nxt_x_d;
  logic [6:0]  nxt_y_q, nxt_y_d;
  logic        pending_q, pending_d;
  logic [7:0]  tick_missed_q, tick_missed_d;
  logic        plot_req_q, plot_req_d;

  logic [7:0]  step_x;
  logic [6:0]  step_y;
  logic        ack_seen;
  logic        in_plot_state;

  assign ack_seen      = plot_req_q && plot_ack;
  assign in_plot_state = (state_q == S_INIT) || (state_q == S_ERASE) ||
                         (state_q == S_DRAW);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_INIT;
      pos_x_q       <= X_INIT;
      pos_y_q       <= Y_INIT;
      nxt_x_q       <= X_INIT;
      nxt_y_q       <= Y_INIT;
      pending_q     <= 1'b0;
      tick_missed_q <= '0;
      plot_req_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      nxt_x_q       <= nxt_x_d;
      nxt_y_q       <= nxt_y_d;
      pending_q     <= pending_d;
      tick_missed_q <= tick_missed_d;
      plot_req_q    <= plot_req_d;
    end
  end

  // Candidate position for a step from the current one; equals the current
  // position when no key is held or the move is blocked at an edge.
  always_comb begin
    step_x = pos_x_q;
    step_y = pos_y_q;
    if (dir[3]) begin
      if (pos_y_q != '0)  step_y = pos_y_q - 7'd1;
      else if (WRAP)      step_y = Y_MAX;
    end else if (dir[2]) begin
      if (pos_y_q < Y_MAX) step_y = pos_y_q + 7'd1;
      else if (WRAP)       step_y = '0;
    end else if (dir[1]) begin
      if (pos_x_q != '0)  step_x = pos_x_q - 8'd1;
      else if (WRAP)      step_x = X_MAX;
    end else if (dir[0]) begin
      if (pos_x_q < X_MAX) step_x = pos_x_q + 8'd1;
      else if (WRAP)       step_x = '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    nxt_x_d       = nxt_x_q;
    nxt_y_d       = nxt_y_q;
    pending_d     = pending_q;
    tick_missed_d = tick_missed_q;

    // One tick may be queued while busy; further ones are only counted.
    if ((state_q != S_IDLE) && tick) begin
      if (!pending_q)                pending_d     = 1'b1;
      else if (tick_missed_q != '1)  tick_missed_d = tick_missed_q + 8'd1;
    end

    unique case (state_q)
      S_INIT:   if (ack_seen) state_d = S_IDLE;
      S_IDLE: begin
        if (tick || pending_q) begin
          pending_d = 1'b0;
          if ((step_x != pos_x_q) || (step_y != pos_y_q)) begin
            nxt_x_d = step_x;
            nxt_y_d = step_y;
            state_d = S_ERASE;
          end
        end
      end
      S_ERASE:  if (ack_seen) state_d = S_UPDATE;
      S_UPDATE: begin
        pos_x_d = nxt_x_q;
        pos_y_d = nxt_y_q;
        state_d = S_DRAW;
      end
      S_DRAW:   if (ack_seen) state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase

    // Registered request: rises one cycle after entering a plot state and
    // drops on the cycle after the accepting edge.
    plot_req_d = in_plot_state && !ack_seen;
  end

  // Outputs. The sprite position only moves in S_UPDATE, so it serves as the
  // plot coordinate for both the erase (old pos) and the draw (new pos).
  always_comb begin
    plot_req    = plot_req_q;
    plot_x      = pos_x_q;
    plot_y      = pos_y_q;
    plot_colour = (state_q == S_ERASE) ? BG_COLOUR : FG_COLOUR;
    pos_x       = pos_x_q;
    pos_y       = pos_y_q;
    busy        = (state_q != S_IDLE);
    tick_missed = tick_missed_q;
  end

endmodule
